perspective_correct: RTL and testbench

//  Perspective-correction stage of the raster back end. It consumes interpolated per-fragment
//  inv_z, u/z and v/z (16.16 fixed point) and derives z through the 1/x unit. It then recovers
//  u = (u/z)*z and v = (v/z)*z and hands fragments to the texture sampler.

---
 rtl/perspective_correct_pkg.sv | 33 +++
 rtl/perspective_correct_if.sv | 36 +++
 rtl/perspective_correct_reciprocal.sv | 65 ++++++
 rtl/perspective_correct.sv | 123 ++++++++++++
 tb/tb_perspective_correct.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/perspective_correct_pkg.sv
// persp_pkg: shared fragment type, fixed-point constants and the 16.16 multiply helper.
// GRAPHITE_PERSP_SAT_EN selects saturating u/v products instead of wrap-around.
package persp_pkg;

   localparam int          PKG_COORD_W = 16;
   localparam logic [31:0] FX_ONE      = 32'h0001_0000;
   localparam logic [31:0] Z_SAT       = 32'h7FFF_FFFF;

   // 256.0 in 16.16: numerator of the reciprocal table, so table entries are 16.16 values of 256/(256+i)
   localparam logic [31:0] RECIP_NUM   = FX_ONE << 8;
   localparam int          RECIP_LUT_N = 256;

   typedef struct packed {
      logic [PKG_COORD_W-1:0] x;
      logic [PKG_COORD_W-1:0] y;
      logic [31:0]            inv_z;
      logic [31:0]            u_z;
      logic [31:0]            v_z;
      logic                   degen;
   } frag_t;

   // Signed 16.16 x 16.16 -> 16.16, taking product[47:16] (truncation toward -inf).
   function automatic logic [31:0] fx_mul(input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] prod;
      prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
`ifdef GRAPHITE_PERSP_SAT_EN
      if (prod[63:47] != {17{prod[63]}})
         return prod[63] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
      return 32'(prod >>> 16);
   endfunction

endpackage

// File: rtl/perspective_correct_if.sv
// Fragment stream interface of the perspective-correction stage: input fragment side,
// output fragment side, and both handshakes. slave = the stage, master = its environment.
interface perspective_correct_if
   import persp_pkg::*;
#(
   parameter int COORD_W = PKG_COORD_W
);

   logic               in_valid_i;
   logic               in_ready_o;
   logic [COORD_W-1:0] x_i;
   logic [COORD_W-1:0] y_i;
   logic [31:0]        inv_z_i;
   logic [31:0]        u_z_i;
   logic [31:0]        v_z_i;

   logic               out_valid_o;
   logic               out_ready_i;
   logic [COORD_W-1:0] x_o;
   logic [COORD_W-1:0] y_o;
   logic [31:0]        z_o;
   logic [31:0]        u_o;
   logic [31:0]        v_o;
   logic               degen_o;

   modport slave (
      input  in_valid_i, x_i, y_i, inv_z_i, u_z_i, v_z_i, out_ready_i,
      output in_ready_o, out_valid_o, x_o, y_o, z_o, u_o, v_o, degen_o
   );

   modport master (
      output in_valid_i, x_i, y_i, inv_z_i, u_z_i, v_z_i, out_ready_i,
      input  in_ready_o, out_valid_o, x_o, y_o, z_o, u_o, v_o, degen_o
   );

endinterface

// File: rtl/perspective_correct_reciprocal.sv
// reciprocal: registered 1/x unit, z = 256/x in 16.16, via a 257-entry table with linear interpolation.
// Non-positive inputs and results above 0x7FFF_FFFF return Z_SAT.
module reciprocal
   import persp_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] x_i,
   output logic [31:0] z_o
);

   logic [16:0] lut [0:RECIP_LUT_N];

   genvar gi;
   generate
      for (gi = 0; gi <= RECIP_LUT_N; gi++) begin : g_lut
         // round(2^24 / (256 + gi)): 16.16 value of 1/mantissa for mantissa 1 + gi/256
         assign lut[gi] = 17'((RECIP_NUM + 32'(128 + gi / 2)) / 32'(256 + gi));
      end
   endgenerate

   logic [4:0] lead;
   always_comb begin
      lead = 5'd0;
      for (int b = 0; b < 31; b++) begin
         if (x_i[b]) lead = 5'(b);
      end
   end

   logic [30:0] norm;
   logic [7:0]  idx;
   logic [7:0]  frac;
   assign norm = x_i[30:0] << (5'd30 - lead);
   assign idx  = norm[29:22];
   assign frac = norm[21:14];

   logic [16:0] lut_a;
   logic [16:0] lut_b;
   logic [16:0] delta;
   logic [24:0] prod_df;
   logic [16:0] r;
   assign lut_a   = lut[{1'b0, idx}];
   assign lut_b   = lut[{1'b0, idx} + 9'd1];
   assign delta   = lut_a - lut_b;
   assign prod_df = 25'(delta) * 25'(frac);
   assign r       = lut_a - prod_df[24:8];

   // x = 2^lead * mantissa, so 2^40/x = r * 2^(24 - lead) with r = 2^16/mantissa
   logic [63:0] scaled;
   assign scaled = ({47'd0, r} << 24) >> lead;

   logic [31:0] z_next;
   assign z_next = ($signed(x_i) <= 32'sd0 || scaled[63:31] != '0) ? Z_SAT : scaled[31:0];

   logic [31:0] z_reg;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) z_reg <= '0;
      else        z_reg <= z_next;
   end
   assign z_o = z_reg;

   logic unused_bits;
   assign unused_bits = ^{norm[30], norm[13:0], prod_df[7:0]};

endmodule

// File: rtl/perspective_correct.sv
// perspective_correct: S1 input reg -> S2 reciprocal (z) -> S3 multiply/output reg, global stall.
// Optional GRAPHITE_PERSP_SAT_EN saturates u/v products (inside persp_pkg::fx_mul).
module perspective_correct
   import persp_pkg::*;
#(
   parameter int COORD_W = PKG_COORD_W
)(
   input  logic                clk,
   input  logic                reset_n_i,
   perspective_correct_if.slave bus
);

   // Asynchronous assert, synchronous release of the internal reset.
   logic rst_meta_reg;
   logic rst_sync_reg;
   logic rst_n;
   always_ff @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rst_meta_reg <= 1'b0;
         rst_sync_reg <= 1'b0;
      end else begin
         rst_meta_reg <= 1'b1;
         rst_sync_reg <= rst_meta_reg;
      end
   end
   assign rst_n = rst_sync_reg;

   logic s1_valid_reg;
   logic s2_valid_reg;
   logic s3_valid_reg;
   logic advance;
   assign advance        = !s3_valid_reg || bus.out_ready_i;
   assign bus.in_ready_o = advance;

   frag_t s1_next;
   frag_t s1_reg;
   frag_t s2_reg;
   always_comb begin
      s1_next       = '0;
      s1_next.x     = PKG_COORD_W'(bus.x_i);
      s1_next.y     = PKG_COORD_W'(bus.y_i);
      s1_next.inv_z = bus.inv_z_i;
      s1_next.u_z   = bus.u_z_i;
      s1_next.v_z   = bus.v_z_i;
      s1_next.degen = ($signed(bus.inv_z_i) <= 32'sd0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_reg <= 1'b0;
         s1_reg       <= '0;
         s2_valid_reg <= 1'b0;
         s2_reg       <= '0;
      end else if (advance) begin
         s1_valid_reg <= bus.in_valid_i;
         s1_reg       <= s1_next;
         s2_valid_reg <= s1_valid_reg;
         s2_reg       <= s1_reg;
      end
   end

   // The reciprocal always clocks; feeding it the S2 copy while stalled keeps z aligned with S2.
   logic [31:0] recip_x;
   logic [31:0] z_s2;
   assign recip_x = advance ? s1_reg.inv_z : s2_reg.inv_z;

   reciprocal u_recip (
      .clk   (clk),
      .rst_n (rst_n),
      .x_i   (recip_x),
      .z_o   (z_s2)
   );

   logic [31:0] z_next;
   logic [31:0] u_next;
   logic [31:0] v_next;
   always_comb begin
      z_next = z_s2;
      u_next = fx_mul(s2_reg.u_z, z_s2);
      v_next = fx_mul(s2_reg.v_z, z_s2);
      if (s2_reg.degen) begin
         z_next = Z_SAT;
         u_next = '0;
         v_next = '0;
      end
   end

   logic [COORD_W-1:0] x_out_reg;
   logic [COORD_W-1:0] y_out_reg;
   logic [31:0]        z_out_reg;
   logic [31:0]        u_out_reg;
   logic [31:0]        v_out_reg;
   logic               degen_out_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s3_valid_reg  <= 1'b0;
         x_out_reg     <= '0;
         y_out_reg     <= '0;
         z_out_reg     <= '0;
         u_out_reg     <= '0;
         v_out_reg     <= '0;
         degen_out_reg <= 1'b0;
      end else if (advance) begin
         s3_valid_reg  <= s2_valid_reg;
         x_out_reg     <= COORD_W'(s2_reg.x);
         y_out_reg     <= COORD_W'(s2_reg.y);
         z_out_reg     <= z_next;
         u_out_reg     <= u_next;
         v_out_reg     <= v_next;
         degen_out_reg <= s2_reg.degen;
      end
   end

   assign bus.out_valid_o = s3_valid_reg;
   assign bus.x_o         = x_out_reg;
   assign bus.y_o         = y_out_reg;
   assign bus.z_o         = z_out_reg;
   assign bus.u_o         = u_out_reg;
   assign bus.v_o         = v_out_reg;
   assign bus.degen_o     = degen_out_reg;

endmodule

// File: tb/tb_perspective_correct.sv
// Self-checking bench for perspective_correct: directed vectors with hand-computed z/u/v,
// streaming, random backpressure, a 10-cycle stall and reset with fragments in flight.
module tb_perspective_correct;

   logic clk     = 1'b0;
   logic reset_n = 1'b1;
   always #5 clk = ~clk;

   perspective_correct_if #(.COORD_W(16)) bus ();

   perspective_correct #(.COORD_W(16)) dut (
      .clk       (clk),
      .reset_n_i (reset_n),
      .bus       (bus)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   logic [31:0] f_inv [1024];
   logic [31:0] f_u   [1024];
   logic [31:0] f_v   [1024];
   logic [15:0] f_x   [1024];
   logic [15:0] f_y   [1024];
   logic [31:0] e_z   [1024];
   logic [31:0] e_u   [1024];
   logic [31:0] e_v   [1024];
   logic        e_d   [1024];

   // Hand-computed 256/inv_z table (16.16); 0xAAAB and 0xFF81 exercise table rounding and interpolation.
   task automatic set_frag(input int i, input int k);
      logic [31:0] inv, z, ru, rv;
      logic        d;
      longint      pu, pv;
      d = 1'b0;
      case (k)
         0:       begin inv = 32'h0100_0000; z = 32'h0001_0000; end
         1:       begin inv = 32'h0001_0000; z = 32'h0100_0000; end
         2:       begin inv = 32'h0180_0000; z = 32'h0000_AAAB; end
         3:       begin inv = 32'h0100_8000; z = 32'h0000_FF81; end
         4:       begin inv = 32'h0040_0000; z = 32'h0004_0000; end
         5:       begin inv = 32'h0000_8000; z = 32'h0200_0000; end
         6:       begin inv = 32'h0000_0000; z = 32'h7FFF_FFFF; d = 1'b1; end
         default: begin inv = 32'hFFFF_0000; z = 32'h7FFF_FFFF; d = 1'b1; end
      endcase
      ru = $urandom;
      rv = $urandom;
      f_inv[i] = inv;
      f_u[i]   = {{10{ru[21]}}, ru[21:0]};
      f_v[i]   = {{10{rv[21]}}, rv[21:0]};
      f_x[i]   = 16'(i * 3 + 1);
      f_y[i]   = 16'(i) ^ 16'h5A5A;
      pu = longint'($signed(f_u[i])) * longint'($signed(z));
      pv = longint'($signed(f_v[i])) * longint'($signed(z));
      e_z[i] = z;
      e_d[i] = d;
      e_u[i] = d ? 32'h0 : pu[47:16];
      e_v[i] = d ? 32'h0 : pv[47:16];
   endtask

   task automatic test_reset();
      bus.in_valid_i  = 1'b0;
      bus.out_ready_i = 1'b0;
      bus.x_i = '0; bus.y_i = '0;
      bus.inv_z_i = '0; bus.u_z_i = '0; bus.v_z_i = '0;
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({bus.out_valid_o, bus.in_ready_o} !== 2'b01) begin
         n_fail++;
         $display("FAIL reset_handshake: got out_valid=%b in_ready=%b, want 0 1", bus.out_valid_o, bus.in_ready_o);
      end
      n_cmp++;
      if ({bus.x_o, bus.y_o, bus.z_o, bus.u_o, bus.v_o, bus.degen_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_data: got x=%h y=%h z=%h u=%h v=%h degen=%b, want all 0",
                  bus.x_o, bus.y_o, bus.z_o, bus.u_o, bus.v_o, bus.degen_o);
      end
      reset_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release: got out_valid=%b in_ready=%b, want 0 1", bus.out_valid_o, bus.in_ready_o);
      end
   endtask

   // Single fragment, out_ready held 1: must be invalid 2 cycles after the accept edge, valid at 3.
   task automatic send_check(input string name, input logic [31:0] inv, input logic [31:0] u,
                             input logic [31:0] v, input logic [31:0] ez, input logic [31:0] eu,
                             input logic [31:0] ev, input logic ed);
      bus.in_valid_i  = 1'b1;
      bus.out_ready_i = 1'b1;
      bus.x_i = 16'h1234; bus.y_i = 16'hBEEF;
      bus.inv_z_i = inv; bus.u_z_i = u; bus.v_z_i = v;
      @(posedge clk); #1;
      bus.in_valid_i = 1'b0;
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (bus.out_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_latency: got out_valid=%b one cycle early, want 0", name, bus.out_valid_o);
      end
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if ({bus.out_valid_o, bus.x_o, bus.y_o, bus.z_o, bus.u_o, bus.v_o, bus.degen_o}
          !== {1'b1, 16'h1234, 16'hBEEF, ez, eu, ev, ed}) begin
         n_fail++;
         $display("FAIL %s: got valid=%b x=%h y=%h z=%h u=%h v=%h degen=%b, want valid=1 x=1234 y=beef z=%h u=%h v=%h degen=%b",
                  name, bus.out_valid_o, bus.x_o, bus.y_o, bus.z_o, bus.u_o, bus.v_o, bus.degen_o, ez, eu, ev, ed);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      send_check("basic", 32'h0100_0000, 32'h0003_0000, 32'hFFFF_0000,
                 32'h0001_0000, 32'h0003_0000, 32'hFFFF_0000, 1'b0);
   endtask

   task automatic test_degenerate();
      send_check("degen_zero", 32'h0000_0000, 32'h0002_0000, 32'h0005_0000,
                 32'h7FFF_FFFF, 32'h0, 32'h0, 1'b1);
      send_check("degen_neg", 32'hFFFF_0000, 32'h0002_0000, 32'h0005_0000,
                 32'h7FFF_FFFF, 32'h0, 32'h0, 1'b1);
   endtask

   task automatic test_overflow();
      logic [31:0] want_u;
`ifdef GRAPHITE_PERSP_SAT_EN
      want_u = 32'h7FFF_FFFF;
`else
      want_u = 32'hFF00_0000;
`endif
      send_check("overflow", 32'h0001_0000, 32'h7FFF_0000, 32'h0000_0001,
                 32'h0100_0000, want_u, 32'h0000_0100, 1'b0);
   endtask

   task automatic test_recip();
      send_check("recip_lut", 32'h0180_0000, 32'h0003_0000, 32'h0001_0000,
                 32'h0000_AAAB, 32'h0002_0001, 32'h0000_AAAB, 1'b0);
      send_check("recip_interp", 32'h0100_8000, 32'h0002_0000, 32'hFFFF_0000,
                 32'h0000_FF81, 32'h0001_FF02, 32'hFFFF_007F, 1'b0);
      send_check("recip_sat", 32'h0000_0100, 32'h0000_0000, 32'h0000_0001,
                 32'h7FFF_FFFF, 32'h0, 32'h0000_7FFF, 1'b0);
   endtask

   // mode 0: out_ready=1; mode 1: random 50%; mode 2: out_ready=0 for cycles 3..12.
   task automatic run_stream(input string name, input int n, input int mode);
      int          sent = 0, got = 0, cyc = 0, first_cyc = -1, last_cyc = -1, extra = 0;
      bit          holding = 0;
      logic        xfer_in;
      logic [15:0] h_x, h_y;
      logic [31:0] h_z, h_u, h_v;
      logic        h_d;
      while (got < n && cyc < n * 6 + 100) begin
         bus.in_valid_i = (sent < n);
         if (sent < n) begin
            bus.x_i = f_x[sent]; bus.y_i = f_y[sent];
            bus.inv_z_i = f_inv[sent]; bus.u_z_i = f_u[sent]; bus.v_z_i = f_v[sent];
         end
         case (mode)
            0:       bus.out_ready_i = 1'b1;
            1:       bus.out_ready_i = 1'($urandom_range(0, 1));
            default: bus.out_ready_i = !(cyc >= 3 && cyc < 13);
         endcase
         @(negedge clk);
         if (holding) begin
            n_cmp++;
            if ({bus.out_valid_o, bus.x_o, bus.y_o, bus.z_o, bus.u_o, bus.v_o, bus.degen_o}
                !== {1'b1, h_x, h_y, h_z, h_u, h_v, h_d}) begin
               n_fail++;
               $display("FAIL %s_hold cyc %0d: got valid=%b z=%h u=%h v=%h, want valid=1 z=%h u=%h v=%h",
                        name, cyc, bus.out_valid_o, bus.z_o, bus.u_o, bus.v_o, h_z, h_u, h_v);
            end
         end
         holding = 0;
         xfer_in = bus.in_valid_i && bus.in_ready_o;
         if (bus.out_valid_o === 1'b1) begin
            if (bus.out_ready_i) begin
               n_cmp++;
               if ({bus.x_o, bus.y_o, bus.z_o, bus.u_o, bus.v_o, bus.degen_o}
                   !== {f_x[got], f_y[got], e_z[got], e_u[got], e_v[got], e_d[got]}) begin
                  n_fail++;
                  $display("FAIL %s_out #%0d: got x=%h y=%h z=%h u=%h v=%h degen=%b, want x=%h y=%h z=%h u=%h v=%h degen=%b",
                           name, got, bus.x_o, bus.y_o, bus.z_o, bus.u_o, bus.v_o, bus.degen_o,
                           f_x[got], f_y[got], e_z[got], e_u[got], e_v[got], e_d[got]);
               end
               if (first_cyc < 0) first_cyc = cyc;
               last_cyc = cyc;
               got++;
            end else begin
               holding = 1;
               h_x = bus.x_o; h_y = bus.y_o; h_z = bus.z_o;
               h_u = bus.u_o; h_v = bus.v_o; h_d = bus.degen_o;
            end
         end
         if (xfer_in) sent++;
         @(posedge clk); #1;
         cyc++;
      end
      n_cmp++;
      if (got != n) begin
         n_fail++;
         $display("FAIL %s_count: got %0d outputs within budget, want %0d", name, got, n);
      end
      if (mode == 0) begin
         n_cmp++;
         if (first_cyc != 3 || last_cyc != 3 + n - 1) begin
            n_fail++;
            $display("FAIL %s_gapless: got outputs in cycles %0d..%0d, want 3..%0d", name, first_cyc, last_cyc, 3 + n - 1);
         end
      end
      bus.in_valid_i  = 1'b0;
      bus.out_ready_i = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (bus.out_valid_o !== 1'b0) extra++;
      end
      n_cmp++;
      if (extra != 0) begin
         n_fail++;
         $display("FAIL %s_drain: got %0d extra output cycles, want 0", name, extra);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_streaming();
      for (int i = 0; i < 64; i++) set_frag(i, int'($urandom_range(0, 7)));
      run_stream("stream", 64, 0);
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < 1000; i++) set_frag(i, int'($urandom_range(0, 7)));
      run_stream("backpressure", 1000, 1);
   endtask

   task automatic test_stall_hold();
      set_frag(0, 3);
      set_frag(1, 2);
      set_frag(2, 5);
      set_frag(3, 0);
      run_stream("stall", 4, 2);
   endtask

   task automatic test_reset_midstream();
      int stale = 0;
      for (int i = 0; i < 3; i++) set_frag(i, i);
      for (int i = 0; i < 3; i++) begin
         bus.in_valid_i = 1'b1; bus.out_ready_i = 1'b1;
         bus.x_i = f_x[i]; bus.y_i = f_y[i];
         bus.inv_z_i = f_inv[i]; bus.u_z_i = f_u[i]; bus.v_z_i = f_v[i];
         @(posedge clk); #1;
      end
      bus.in_valid_i  = 1'b0;
      bus.out_ready_i = 1'b0;
      n_cmp++;
      if (bus.out_valid_o !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_inflight: got out_valid=%b before reset, want 1", bus.out_valid_o);
      end
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if (bus.out_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_immediate: got out_valid=%b during reset, want 0", bus.out_valid_o);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      bus.out_ready_i = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (bus.in_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_ready: got in_ready=%b after release, want 1", bus.in_ready_o);
      end
      repeat (6) begin
         @(negedge clk);
         if (bus.out_valid_o !== 1'b0) stale++;
      end
      n_cmp++;
      if (stale != 0) begin
         n_fail++;
         $display("FAIL midrst_stale: got %0d cycles with out_valid after reset, want 0", stale);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_degenerate();
      test_overflow();
      test_recip();
      test_streaming();
      test_backpressure();
      test_stall_hold();
      test_reset_midstream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish by 1000000 time units, want finish");
      $fatal(1, "watchdog expired");
   end

endmodule
